lcd_ctrl: RTL and testbench
===========================

// Module: lcd_ctrl
// PURPOSE
//   Sequences HD44780-style character-LCD transfers for the singlecycle SoC I/O block.
//   LSU writes to the LCD MMIO slot arrive as byte commands and are queued in a small FIFO.
//   The block generates the timed RS/RW/EN/DATA waveform and drives the packed o_io_lcd word, so software never bit-bangs EN timing.
//   Optionally runs the power-on init sequence on its own.
// PARAMETERS
//   FIFO_DEPTH   8        command FIFO entries; power of 2, >=2
//   T_PWRUP_CYC  750000   cycles idle after reset before any LCD access (15 ms @ 50 MHz)
//   T_EN_CYC     25       EN high width, cycles
//   T_CMD_CYC    2500     post-EN wait for normal commands/data (50 us)
//   T_CLR_CYC    82000    post-EN wait for clear/home (RS=0, data 0x01 or 0x02)
// PORTS
//   i_clk        in   1   system clock
//   i_rst_n      in   1   asynchronous active-low reset
//   i_cmd_valid  in   1   push request from LSU MMIO decode
//   o_cmd_ready  out  1   FIFO not full; push occurs when valid&&ready at posedge
//   i_cmd_rs     in   1   0=instruction, 1=character data
//   i_cmd_data   in   8   command/character byte
//   o_busy       out  1   FSM not in IDLE, or FIFO non-empty
//   o_init_done  out  1   power-up (and auto-init if enabled) complete; sticky until reset
//   o_io_lcd     out  32  [31]=ON [10]=EN [9]=RS [8]=RW [7:0]=DATA; other bits 0
// BEHAVIOUR
//   Reset: o_io_lcd=0, o_busy=1, o_init_done=0, o_cmd_ready=1, FIFO empty, FSM=PWRUP, counters=0.
//   Reset is asynchronous; asserting it mid-transfer forces EN=0 immediately, and queued commands are lost.
//   ON (bit 31) is set on the first cycle after reset release and stays 1. RW is always 0 (write-only controller).
//   FSM states:
//     PWRUP: count T_PWRUP_CYC cycles, then go to INIT (if AUTOINIT) or IDLE.
//     INIT: load the next init ROM entry as the current command, then go to SETUP. After the last entry, go to IDLE.
//     IDLE: if FIFO non-empty, pop the head into the current command and go to SETUP.
//     SETUP: 1 cycle; DATA/RS driven, EN=0.
//     PULSE: EN=1 for exactly T_EN_CYC cycles; DATA/RS held stable.
//     HOLD: EN=0 with DATA/RS held; wait T_CLR_CYC if (RS=0 && DATA in {0x01,0x02}), else T_CMD_CYC. Then return to INIT or IDLE.
//   Every transfer is SETUP(1) + PULSE(T_EN_CYC) + HOLD(wait) cycles; back-to-back commands get no extra gap.
//   o_init_done rises on the PWRUP->IDLE or INIT->IDLE transition.
//   FIFO pushes are accepted in any state, including PWRUP. A push while full is ignored (ready=0).
//   A simultaneous push and pop while full is not accepted: ready is computed from the registered count.
//   Simultaneous push/pop when non-full and non-empty keeps the count unchanged; pointers wrap modulo FIFO_DEPTH.
//   FIFO count width is $clog2(FIFO_DEPTH)+1.
//   Wait counters saturate at their terminal value and are cleared on each state entry.
// CONFIGURATION
//   LCD_CTRL_AUTOINIT_EN defined: after PWRUP, issue ROM {0x38,0x0C,0x01,0x06} (RS=0), each with full transfer timing.
//   LCD_CTRL_AUTOINIT_EN undefined: PWRUP goes straight to IDLE, and software issues the init commands. The INIT state and ROM are not built.
// STRUCTURE
//   lcd_pkg provides:
//     state enum {PWRUP, INIT, IDLE, SETUP, PULSE, HOLD};
//     LCD_ON_BIT=31, LCD_EN_BIT=10, LCD_RS_BIT=9, LCD_RW_BIT=8;
//     the init ROM constant array; CMD_CLEAR=8'h01, CMD_HOME=8'h02;
//     the packed cmd struct {rs, data[7:0]}.
//   Sub-module lcd_cmd_fifo is a synchronous FIFO of 9-bit cmd entries with full, empty, and count outputs.
//   The FSM, wait counter, and output register live in lcd_ctrl.
// TESTING (bench params: FIFO_DEPTH=4, T_PWRUP_CYC=20, T_EN_CYC=2, T_CMD_CYC=5, T_CLR_CYC=10)
//   1. Reset, then release. Expect o_io_lcd=0x80000000 after 1 cycle and o_busy=1 during power-up.
//      Without AUTOINIT: o_init_done rises after 20 cycles.
//   2. With AUTOINIT, release reset with no pushes.
//      Expect 4 EN pulses with DATA 0x38, 0x0C, 0x01, 0x06 (RS=0), each EN high exactly 2 cycles.
//      Expect a 10-cycle HOLD after 0x01 and 5-cycle HOLDs elsewhere; o_init_done rises after the last HOLD.
//   3. After init, push RS=1 DATA=0x41.
//      Expect o_io_lcd=0x80000241 in SETUP, 0x80000641 for 2 cycles, then 0x80000241 for 5 cycles.
//      Expect o_busy to drop after that.
//   4. During PWRUP, push 5 commands back-to-back.
//      Expect o_cmd_ready=0 after the 4th and the 5th ignored; exactly 4 transfers emitted in push order.
//   5. Push RS=0 0x02 then RS=1 0x30.
//      Expect a 10-cycle HOLD for 0x02 and a 5-cycle HOLD for 0x30, with no idle gap between transfers.
//   6. Assert i_rst_n during PULSE.
//      Expect EN=0 and o_io_lcd=0 asynchronously, and the FIFO empty after release.
//      PWRUP restarts its full count.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the character-LCD controller
package lcd_pkg;

   typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, PULSE, HOLD} lcd_state_e;

   localparam int LCD_ON_BIT = 31;
   localparam int LCD_EN_BIT = 10;
   localparam int LCD_RS_BIT = 9;
   localparam int LCD_RW_BIT = 8;

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcd_cmd_t;

   // Entry 0 is issued first: function set, display on, clear, entry mode.
   localparam int INIT_ROM_LEN = 4;
   localparam logic [INIT_ROM_LEN-1:0][7:0] INIT_ROM = {8'h06, CMD_CLEAR, 8'h0C, 8'h38};

   function automatic logic is_slow_cmd(input lcd_cmd_t cmd);
      return !cmd.rs && (cmd.data == CMD_CLEAR || cmd.data == CMD_HOME);
   endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// rtl/lcd_cmd_fifo.sv - synchronous FIFO of LCD byte commands
module lcd_cmd_fifo
   import lcd_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  lcd_cmd_t               wdata_i,
   input  logic                   pop_i,
   output lcd_cmd_t               rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q;
   lcd_cmd_t      mem_q [DEPTH];
   logic          do_push, do_pop;

   // Full is taken from the registered count, so a pop cannot make room for a same-cycle push.
   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780-style LCD transfer sequencer with command FIFO
// Define LCD_CTRL_AUTOINIT_EN to run the power-on init sequence in hardware.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int T_PWRUP_CYC = 750000,
   parameter int T_EN_CYC    = 25,
   parameter int T_CMD_CYC   = 2500,
   parameter int T_CLR_CYC   = 82000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic        i_cmd_rs,
   input  logic [7:0]  i_cmd_data,
   output logic        o_busy,
   output logic        o_init_done,
   output logic [31:0] o_io_lcd
);

   localparam int MAX_A   = (T_PWRUP_CYC > T_CLR_CYC) ? T_PWRUP_CYC : T_CLR_CYC;
   localparam int MAX_B   = (T_CMD_CYC > T_EN_CYC) ? T_CMD_CYC : T_EN_CYC;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(T_PWRUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(T_CMD_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(T_CLR_CYC - 1);

   lcd_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_term, hold_last;
   lcd_cmd_t         cmd_q, cmd_d, fifo_head, fifo_wdata;
   logic             done_q, done_d;
   logic [31:0]      io_q, io_d;
   logic             fifo_pop, fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

`ifdef LCD_CTRL_AUTOINIT_EN
   localparam int ROM_AW = $clog2(INIT_ROM_LEN);
   localparam int IDX_W  = $clog2(INIT_ROM_LEN + 1);
   logic [IDX_W-1:0] idx_q, idx_d;
`endif

   assign fifo_wdata.rs   = i_cmd_rs;
   assign fifo_wdata.data = i_cmd_data;

   lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .push_i  (i_cmd_valid),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign o_cmd_ready = !fifo_full;
   assign o_busy      = (state_q != IDLE) || (fifo_count != '0);
   assign o_init_done = done_q;
   assign o_io_lcd    = io_q;
   assign hold_last   = is_slow_cmd(cmd_q) ? CLR_LAST : CMD_LAST;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= PWRUP;
         cnt_q   <= '0;
         cmd_q   <= '0;
         done_q  <= 1'b0;
         io_q    <= '0;
`ifdef LCD_CTRL_AUTOINIT_EN
         idx_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         done_q  <= done_d;
         io_q    <= io_d;
`ifdef LCD_CTRL_AUTOINIT_EN
         idx_q   <= idx_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      done_d   = done_q;
      fifo_pop = 1'b0;
`ifdef LCD_CTRL_AUTOINIT_EN
      idx_d    = idx_q;
`endif
      case (state_q)
         PWRUP:   cnt_term = PWRUP_LAST;
         PULSE:   cnt_term = EN_LAST;
         HOLD:    cnt_term = hold_last;
         default: cnt_term = '0;
      endcase
      cnt_d = (cnt_q == cnt_term) ? cnt_q : cnt_q + 1'b1;

      case (state_q)
         PWRUP: begin
            if (cnt_q == PWRUP_LAST) begin
`ifdef LCD_CTRL_AUTOINIT_EN
               state_d = INIT;
`else
               state_d = IDLE;
               done_d  = 1'b1;
`endif
            end
         end
`ifdef LCD_CTRL_AUTOINIT_EN
         INIT: begin
            if (idx_q == IDX_W'(INIT_ROM_LEN)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cmd_d.rs   = 1'b0;
               cmd_d.data = INIT_ROM[idx_q[ROM_AW-1:0]];
               idx_d      = idx_q + 1'b1;
               state_d    = SETUP;
            end
         end
`endif
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               cmd_d    = fifo_head;
               state_d  = SETUP;
            end
         end
         SETUP: state_d = PULSE;
         PULSE: if (cnt_q == EN_LAST) state_d = HOLD;
         HOLD: begin
            // Chain straight into the next queued transfer so there is no idle cycle between them.
            if (cnt_q == hold_last) begin
`ifdef LCD_CTRL_AUTOINIT_EN
               if (!done_q) state_d = INIT;
               else
`endif
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  cmd_d    = fifo_head;
                  state_d  = SETUP;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) cnt_d = '0;
   end

   // Output word is registered from next-state so the pins line up with state_q.
   always_comb begin
      io_d             = '0;
      io_d[LCD_ON_BIT] = 1'b1;
      io_d[LCD_RW_BIT] = 1'b0;
      if (state_d == SETUP || state_d == PULSE || state_d == HOLD) begin
         io_d[7:0]        = cmd_d.data;
         io_d[LCD_RS_BIT] = cmd_d.rs;
         io_d[LCD_EN_BIT] = (state_d == PULSE);
      end
   end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - scoreboard bench for lcd_ctrl
// Build with LCD_CTRL_AUTOINIT_EN defined to also check the hardware init sequence.
module tb_lcd_ctrl;

   localparam logic [3:0][7:0] INIT_SEQ = {8'h06, 8'h01, 8'h0C, 8'h38};

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_rs;
   logic [7:0]  cmd_data;
   logic        cmd_ready, busy, init_done;
   logic [31:0] io_lcd;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];
   int   rise_q[$];
   bit   in_pulse = 1'b0;
   bit   in_hold  = 1'b0;

   always #5 clk = ~clk;

   lcd_ctrl #(
      .FIFO_DEPTH  (4),
      .T_PWRUP_CYC (20),
      .T_EN_CYC    (2),
      .T_CMD_CYC   (5),
      .T_CLR_CYC   (10)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_cmd_valid (cmd_valid),
      .o_cmd_ready (cmd_ready),
      .i_cmd_rs    (cmd_rs),
      .i_cmd_data  (cmd_data),
      .o_busy      (busy),
      .o_init_done (init_done),
      .o_io_lcd    (io_lcd)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] lcd_word(input logic rs, input logic [7:0] d, input logic en);
      return 32'h8000_0000 | (32'(en) << 10) | (32'(rs) << 9) | 32'(d);
   endfunction

   // Monitor: pops the scoreboard at each EN rise and checks setup, pulse and hold phases.
   initial begin
      logic [31:0] w, prev_w, hold_word;
      exp_t cur;
      int en_cnt, hold_cnt, exp_hold, cyc;
      prev_w = '0; hold_word = '0; cur = '0;
      en_cnt = 0; hold_cnt = 0; exp_hold = 0; cyc = 0;
      forever begin
         @(negedge clk);
         w = io_lcd;
         cyc++;
         if (!rst_n) begin
            in_pulse = 1'b0;
            in_hold  = 1'b0;
         end else begin
            if (in_hold) begin
               if (w != hold_word) begin
                  check("hold_len", 32'(hold_cnt), 32'(exp_hold));
                  in_hold = 1'b0;
               end else begin
                  hold_cnt++;
               end
            end
            if (w[10] && !in_pulse) begin
               if (sb.size() == 0) begin
                  check("sb_underflow", 32'(sb.size()), 32'd1);
               end else begin
                  cur = sb.pop_front();
                  exp_hold = (!cur.rs && (cur.data == 8'h01 || cur.data == 8'h02)) ? 10 : 5;
                  check("setup_word", prev_w, lcd_word(cur.rs, cur.data, 1'b0));
                  check("pulse_word", w, lcd_word(cur.rs, cur.data, 1'b1));
               end
               rise_q.push_back(cyc);
               in_pulse = 1'b1;
               en_cnt   = 1;
            end else if (w[10]) begin
               en_cnt++;
            end else if (in_pulse) begin
               in_pulse  = 1'b0;
               check("en_width", 32'(en_cnt), 32'd2);
               hold_word = lcd_word(cur.rs, cur.data, 1'b0);
               check("hold_word", w, hold_word);
               in_hold   = 1'b1;
               hold_cnt  = 1;
            end
         end
         prev_w = w;
      end
   end

   task automatic push(input logic rs, input logic [7:0] d, input logic exp_ready);
      exp_t e;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_rs    = rs;
      cmd_data  = d;
      check("push_ready", 32'(cmd_ready), 32'(exp_ready));
      if (exp_ready) begin
         e.rs   = rs;
         e.data = d;
         sb.push_back(e);
      end
   endtask

   task automatic release_valid();
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic do_reset(input bit timed);
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      #1;
      check("rst_io", io_lcd, 32'h0);
      check("rst_en", 32'(io_lcd[10]), 32'h0);
      check("rst_busy", 32'(busy), 32'h1);
      check("rst_done", 32'(init_done), 32'h0);
      check("rst_ready", 32'(cmd_ready), 32'h1);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
`ifdef LCD_CTRL_AUTOINIT_EN
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         e.rs   = 1'b0;
         e.data = INIT_SEQ[i];
         sb.push_back(e);
      end
`endif
      if (timed) begin
         @(negedge clk);
         check("on_after_1", io_lcd, 32'h8000_0000);
         check("pwrup_busy", 32'(busy), 32'h1);
         repeat (18) @(negedge clk);
         check("pwrup_done_19", 32'(init_done), 32'h0);
`ifndef LCD_CTRL_AUTOINIT_EN
         @(negedge clk);
         check("pwrup_done_20", 32'(init_done), 32'h1);
         check("fifo_empty_idle", 32'(busy), 32'h0);
`endif
      end
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((busy || sb.size() != 0 || in_pulse || in_hold) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_sb_left"}, 32'(sb.size()), 32'h0);
      check({tag, "_done"}, 32'(init_done), 32'h1);
      check({tag, "_io"}, io_lcd, 32'h8000_0000);
   endtask

   initial begin
      int n;
      rst_n     = 1'b1;
      cmd_valid = 1'b0;
      cmd_rs    = 1'b0;
      cmd_data  = 8'h00;
      #2;

      do_reset(1'b1);
      drain("init", 300);

      push(1'b1, 8'h41, 1'b1);
      release_valid();
      repeat (8) @(negedge clk);
      check("t3_busy_hold", 32'(busy), 32'h1);
      @(negedge clk);
      check("t3_busy_drop", 32'(busy), 32'h0);
      drain("t3", 50);

      do_reset(1'b0);
      for (int i = 0; i < 5; i++) push(1'b1, 8'h50 + 8'(i), (i < 4));
      release_valid();
      drain("t4", 400);

      rise_q.delete();
      push(1'b0, 8'h02, 1'b1);
      push(1'b1, 8'h30, 1'b1);
      release_valid();
      drain("t5", 100);
      check("t5_nrise", 32'(rise_q.size()), 32'd2);
      if (rise_q.size() == 2) check("t5_period", 32'(rise_q[1] - rise_q[0]), 32'd13);

      push(1'b1, 8'h48, 1'b1);
      push(1'b1, 8'h49, 1'b1);
      release_valid();
      n = 0;
      while (!io_lcd[10] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t6_en_seen", 32'(io_lcd[10]), 32'h1);
      do_reset(1'b1);
      drain("t6", 300);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
